// File: rtl/gb_oam_dma.sv
`timescale 1ns/1ps
// gb_oam_dma: OAM DMA engine and bus arbiter between the core and the shared
// memory bus. A write to the DMA register copies 160 bytes from {src_hi,00}
// into OAM, fencing the core off the bus until the copy finishes.
module gb_oam_dma #(
    parameter int unsigned OAM_LEN  = 160,
    parameter logic [15:0] OAM_BASE = 16'hFE00,
    parameter logic [15:0] DMA_REG  = 16'hFF46
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic [15:0] core_address,
    input  logic [7:0]  core_data_in,
    output logic [7:0]  core_data_out,
    input  logic        core_nread,
    input  logic        core_nwrite,
    output logic [15:0] bus_address,
    output logic [7:0]  bus_data_out,
    input  logic [7:0]  bus_data_in,
    output logic        bus_nread,
    output logic        bus_nwrite,
    output logic        dma_active
);

    localparam logic [7:0] LAST_IDX = 8'(OAM_LEN - 1);

    typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;

    state_t     state, state_next;
    logic [7:0] src_hi;
    logic [7:0] idx;
    logic [7:0] byte_buf;
    logic       wr_prev;
    logic       reg_sel;
    logic       reg_wr;
    logic       trigger;
    logic [7:0] mapped_hi;

    assign reg_sel   = (core_address == DMA_REG);
    assign reg_wr    = reg_sel && !core_nwrite;
    assign trigger   = reg_wr && !wr_prev;
    // Echo RAM sources (E0..FF) read from the WRAM they mirror.
    assign mapped_hi = (src_hi >= 8'hE0) ? (src_hi - 8'h20) : src_hi;
    assign dma_active = (state != IDLE);

    // State register.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state: a trigger restarts from any state.
    always_comb begin
        state_next = state;
        if (trigger) begin
            state_next = START;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                START:   state_next = READ;
                READ:    state_next = WRITE;
                WRITE:   state_next = (idx == LAST_IDX) ? IDLE : READ;
                default: state_next = IDLE;
            endcase
        end
    end

    // Source page, byte index, staging buffer and write-strobe history.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            src_hi   <= 8'hFF;
            idx      <= '0;
            byte_buf <= '0;
            wr_prev  <= 1'b0;
        end else begin
            wr_prev <= reg_wr;
            if (trigger) begin
                src_hi <= core_data_in;
                idx    <= '0;
            end else begin
                if (state == READ) byte_buf <= bus_data_in;
                if (state == WRITE && idx != LAST_IDX) idx <= idx + 8'd1;
            end
        end
    end

    // Bus ownership and core read-back mux.
    always_comb begin
        bus_address   = core_address;
        bus_data_out  = core_data_in;
        bus_nread     = 1'b1;
        bus_nwrite    = 1'b1;
        core_data_out = 8'hFF;
        case (state)
            IDLE: begin
                if (!reg_sel) begin
                    bus_nread     = core_nread;
                    bus_nwrite    = core_nwrite;
                    core_data_out = bus_data_in;
                end
            end
            READ: begin
                bus_address = {mapped_hi, idx};
                bus_nread   = 1'b0;
            end
            WRITE: begin
                bus_address  = OAM_BASE + {8'h00, idx};
                bus_data_out = byte_buf;
                // A retrigger landing in this cycle abandons the pending byte.
                bus_nwrite   = trigger;
            end
            default: ;
        endcase
        if (reg_sel) core_data_out = src_hi;
    end

endmodule

// File: tb/tb_gb_oam_dma.sv
`timescale 1ns/1ps
// Self-checking bench for gb_oam_dma: memory model on the bus, scoreboard of
// expected bus operations, one task per scenario.
module tb_gb_oam_dma;

    localparam logic [15:0] DMA_REG = 16'hFF46;

    logic        clock = 1'b0;
    logic        nreset;
    logic [15:0] core_address;
    logic [7:0]  core_data_in;
    logic [7:0]  core_data_out;
    logic        core_nread;
    logic        core_nwrite;
    logic [15:0] bus_address;
    logic [7:0]  bus_data_out;
    logic [7:0]  bus_data_in;
    logic        bus_nread;
    logic        bus_nwrite;
    logic        dma_active;

    gb_oam_dma dut (
        .clock(clock), .nreset(nreset),
        .core_address(core_address), .core_data_in(core_data_in),
        .core_data_out(core_data_out), .core_nread(core_nread),
        .core_nwrite(core_nwrite), .bus_address(bus_address),
        .bus_data_out(bus_data_out), .bus_data_in(bus_data_in),
        .bus_nread(bus_nread), .bus_nwrite(bus_nwrite),
        .dma_active(dma_active)
    );

    always #5 clock = ~clock;

    logic [7:0] mem [0:65535];
    assign bus_data_in = mem[bus_address];
    always @(posedge clock) if (!bus_nwrite) mem[bus_address] <= bus_data_out;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } op_t;

    op_t exp_q[$];
    op_t got_q[$];
    int  checks = 0;
    int  failures = 0;

    task automatic core_idle();
        core_address = 16'h0000;
        core_data_in = 8'h00;
        core_nread   = 1'b1;
        core_nwrite  = 1'b1;
    endtask

    task automatic load_src(input logic [15:0] base);
        for (int k = 0; k < 160; k++) begin
            mem[base + 16'(k)]    <= 8'($urandom_range(1, 255));
            mem[16'hFE00 + 16'(k)] <= 8'h00;
        end
        #1;
    endtask

    task automatic push_copy(input logic [7:0] hi, input int n_rd, input int n_wr);
        for (int k = 0; k < n_rd; k++) begin
            exp_q.push_back({1'b0, hi, 8'(k), 8'h00});
            if (k < n_wr) exp_q.push_back({1'b1, 16'hFE00 + 16'(k), mem[{hi, 8'(k)}]});
        end
    endtask

    task automatic start_dma(input logic [7:0] hi);
        @(posedge clock);
        #1;
        core_address = DMA_REG;
        core_data_in = hi;
        core_nread   = 1'b1;
        core_nwrite  = 1'b0;
    endtask

    // Records bus operations cycle by cycle; optionally retriggers (kind 1)
    // or resets (kind 2) at the read of at_addr.
    task automatic watch_bus(input int hold, input int kind, input logic [15:0] at_addr,
                             input logic [7:0] re_hi, output int act, output int starts,
                             output int both_low, output logic rst_active,
                             output logic [15:0] rst_addr, output logic rst_nread);
        int rel_c;
        act = 0; starts = 0; both_low = 0; rel_c = hold;
        rst_active = 1'b1; rst_addr = '0; rst_nread = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clock);
            if (dma_active) act++;
            else if (act > 0) break;
            if (!bus_nread && !bus_nwrite) both_low++;
            if (dma_active && bus_nread && bus_nwrite) starts++;
            if (!bus_nread || !bus_nwrite)
                got_q.push_back({~bus_nwrite, bus_address, bus_nwrite ? 8'h00 : bus_data_out});
            if (c == rel_c) core_idle();
            if (kind != 0 && !bus_nread && bus_address == at_addr) begin
                if (kind == 1) begin
                    core_address = DMA_REG;
                    core_data_in = re_hi;
                    core_nwrite  = 1'b0;
                    rel_c = c + 1;
                end else begin
                    nreset = 1'b0;
                    core_address = 16'hC000;
                    core_nread = 1'b0;
                    #1;
                    rst_active = dma_active;
                    rst_addr   = bus_address;
                    rst_nread  = bus_nread;
                    @(negedge clock);
                    nreset = 1'b1;
                    core_idle();
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        core_idle();
        mem[16'hC123] <= 8'h5A;
        repeat (2) @(negedge clock);
        checks++;
        if (dma_active !== 1'b0) begin failures++; $display("FAIL reset_active got=%b expected=0", dma_active); end
        nreset = 1'b1;
        core_address = DMA_REG; core_nread = 1'b0;
        #1;
        checks++;
        if (core_data_out !== 8'hFF) begin failures++; $display("FAIL reset_reg_read got=%h expected=ff", core_data_out); end
        checks++;
        if ({bus_nread, bus_nwrite} !== 2'b11) begin failures++; $display("FAIL reset_reg_strobes got=%b expected=11", {bus_nread, bus_nwrite}); end
        core_address = 16'hC123;
        #1;
        checks++;
        if (core_data_out !== 8'h5A || bus_address !== 16'hC123 || bus_nread !== 1'b0) begin
            failures++;
            $display("FAIL idle_read got data=%h addr=%h nrd=%b expected data=5a addr=c123 nrd=0", core_data_out, bus_address, bus_nread);
        end
        core_nread = 1'b1; core_address = 16'hC200; core_data_in = 8'h33; core_nwrite = 1'b0;
        #1;
        checks++;
        if (bus_nwrite !== 1'b0 || bus_data_out !== 8'h33 || bus_address !== 16'hC200) begin
            failures++;
            $display("FAIL idle_write got nwr=%b data=%h addr=%h expected nwr=0 data=33 addr=c200", bus_nwrite, bus_data_out, bus_address);
        end
        @(posedge clock);
        #1;
        core_idle();
        checks++;
        if (mem[16'hC200] !== 8'h33) begin failures++; $display("FAIL idle_write_mem got=%h expected=33", mem[16'hC200]); end
    endtask

    task automatic test_full_copy();
        int act, starts, bl, bad;
        logic ra, rn;
        logic [15:0] radr;
        op_t g, e;
        load_src(16'hC100);
        exp_q.delete(); got_q.delete();
        push_copy(8'hC1, 160, 160);
        start_dma(8'hC1);
        watch_bus(1, 0, 16'h0000, 8'h00, act, starts, bl, ra, radr, rn);
        checks++;
        if (act !== 321) begin failures++; $display("FAIL copy_active_cycles got=%0d expected=321", act); end
        checks++;
        if (starts !== 1) begin failures++; $display("FAIL copy_start_cycles got=%0d expected=1", starts); end
        checks++;
        if (bl !== 0) begin failures++; $display("FAIL copy_both_low got=%0d expected=0", bl); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL copy_op extra wr=%b addr=%h data=%h", g.wr, g.addr, g.data);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin
                    failures++;
                    $display("FAIL copy_op got wr=%b addr=%h data=%h expected wr=%b addr=%h data=%h", g.wr, g.addr, g.data, e.wr, e.addr, e.data);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL copy_missing_ops got=%0d expected=0", exp_q.size()); end
        bad = 0;
        for (int k = 0; k < 160; k++)
            if (mem[16'hFE00 + 16'(k)] !== mem[16'hC100 + 16'(k)]) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL copy_oam_contents bad_bytes=%0d expected=0", bad); end
    endtask

    task automatic test_reg_and_fence();
        mem[16'hC000] <= 8'hAA;
        start_dma(8'h80);
        #1;
        checks++;
        if (bus_nwrite !== 1'b1 || bus_nread !== 1'b1) begin failures++; $display("FAIL reg_write_forwarded got=%b%b expected=11", bus_nread, bus_nwrite); end
        @(posedge clock);
        #1;
        core_nwrite = 1'b1; core_address = DMA_REG; core_nread = 1'b0;
        #1;
        checks++;
        if (core_data_out !== 8'h80 || dma_active !== 1'b1) begin
            failures++; $display("FAIL busy_reg_read got data=%h act=%b expected data=80 act=1", core_data_out, dma_active);
        end
        core_address = 16'hC000;
        #1;
        checks++;
        if (core_data_out !== 8'hFF) begin failures++; $display("FAIL fenced_read got=%h expected=ff", core_data_out); end
        core_nread = 1'b1; core_data_in = 8'h55; core_nwrite = 1'b0;
        repeat (4) begin
            @(negedge clock);
            checks++;
            if (!bus_nwrite && bus_address == 16'hC000) begin
                failures++; $display("FAIL fenced_write_seen got addr=%h data=%h expected no write", bus_address, bus_data_out);
            end
        end
        core_idle();
        for (int c = 0; c < 400 && dma_active; c++) @(negedge clock);
        checks++;
        if (dma_active !== 1'b0) begin failures++; $display("FAIL fence_wait_idle got=%b expected=0", dma_active); end
        checks++;
        if (mem[16'hC000] !== 8'hAA) begin failures++; $display("FAIL fenced_write_mem got=%h expected=aa", mem[16'hC000]); end
        core_address = DMA_REG; core_nread = 1'b0;
        #1;
        checks++;
        if (core_data_out !== 8'h80 || {bus_nread, bus_nwrite} !== 2'b11) begin
            failures++; $display("FAIL idle_reg_read got data=%h strobes=%b expected data=80 strobes=11", core_data_out, {bus_nread, bus_nwrite});
        end
        core_idle();
    endtask

    task automatic test_hold_write();
        int act, starts, bl;
        logic ra, rn;
        logic [15:0] radr;
        op_t g, e;
        load_src(16'hC100);
        exp_q.delete(); got_q.delete();
        push_copy(8'hC1, 160, 160);
        start_dma(8'hC1);
        watch_bus(5, 0, 16'h0000, 8'h00, act, starts, bl, ra, radr, rn);
        checks++;
        if (act !== 321) begin failures++; $display("FAIL hold_active_cycles got=%0d expected=321", act); end
        checks++;
        if (starts !== 1) begin failures++; $display("FAIL hold_start_cycles got=%0d expected=1", starts); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL hold_op extra wr=%b addr=%h data=%h", g.wr, g.addr, g.data);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin
                    failures++;
                    $display("FAIL hold_op got wr=%b addr=%h data=%h expected wr=%b addr=%h data=%h", g.wr, g.addr, g.data, e.wr, e.addr, e.data);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL hold_missing_ops got=%0d expected=0", exp_q.size()); end
    endtask

    task automatic test_echo_retrigger();
        int act, starts, bl, bad;
        logic ra, rn;
        logic [15:0] radr;
        op_t g, e;
        load_src(16'hC200);
        load_src(16'hD000);
        exp_q.delete(); got_q.delete();
        push_copy(8'hC2, 51, 50);
        push_copy(8'hD0, 160, 160);
        start_dma(8'hE2);
        watch_bus(1, 1, 16'hC232, 8'hD0, act, starts, bl, ra, radr, rn);
        checks++;
        if (act !== 423) begin failures++; $display("FAIL retrig_active_cycles got=%0d expected=423", act); end
        checks++;
        if (starts !== 2) begin failures++; $display("FAIL retrig_start_cycles got=%0d expected=2", starts); end
        checks++;
        if (bl !== 0) begin failures++; $display("FAIL retrig_both_low got=%0d expected=0", bl); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL retrig_op extra wr=%b addr=%h data=%h", g.wr, g.addr, g.data);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin
                    failures++;
                    $display("FAIL retrig_op got wr=%b addr=%h data=%h expected wr=%b addr=%h data=%h", g.wr, g.addr, g.data, e.wr, e.addr, e.data);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL retrig_missing_ops got=%0d expected=0", exp_q.size()); end
        bad = 0;
        for (int k = 0; k < 160; k++)
            if (mem[16'hFE00 + 16'(k)] !== mem[16'hD000 + 16'(k)]) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL retrig_oam_contents bad_bytes=%0d expected=0", bad); end
    endtask

    task automatic test_reset_mid();
        int act, starts, bl, bad;
        logic ra, rn;
        logic [15:0] radr;
        op_t g, e;
        load_src(16'hC100);
        exp_q.delete(); got_q.delete();
        push_copy(8'hC1, 21, 20);
        start_dma(8'hC1);
        watch_bus(1, 2, 16'hC114, 8'h00, act, starts, bl, ra, radr, rn);
        checks++;
        if (ra !== 1'b0) begin failures++; $display("FAIL rstmid_active got=%b expected=0", ra); end
        checks++;
        if (radr !== 16'hC000 || rn !== 1'b0) begin
            failures++; $display("FAIL rstmid_passthru got addr=%h nrd=%b expected addr=c000 nrd=0", radr, rn);
        end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            checks++;
            if (exp_q.size() == 0) begin
                failures++; $display("FAIL rstmid_op extra wr=%b addr=%h data=%h", g.wr, g.addr, g.data);
            end else begin
                e = exp_q.pop_front();
                if (g !== e) begin
                    failures++;
                    $display("FAIL rstmid_op got wr=%b addr=%h data=%h expected wr=%b addr=%h data=%h", g.wr, g.addr, g.data, e.wr, e.addr, e.data);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL rstmid_missing_ops got=%0d expected=0", exp_q.size()); end
        @(negedge clock);
        bad = 0;
        for (int k = 0; k < 160; k++) begin
            if (k < 20 && mem[16'hFE00 + 16'(k)] !== mem[16'hC100 + 16'(k)]) bad++;
            if (k >= 20 && mem[16'hFE00 + 16'(k)] !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL rstmid_oam_contents bad_bytes=%0d expected=0", bad); end
        checks++;
        if (dma_active !== 1'b0) begin failures++; $display("FAIL rstmid_after got=%b expected=0", dma_active); end
    endtask

    initial begin
        core_idle();
        nreset = 1'b0;
        test_reset();
        test_full_copy();
        test_reg_and_fence();
        test_hold_write();
        test_echo_retrigger();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
